// File: rtl/msu_ddram_pkg.sv
// msu_ddram_pkg: shared widths, arbiter state encoding and pending-request record
package msu_ddram_pkg;
  localparam int ADDR_W  = 29;
  localparam int DATA_W  = 64;
  localparam int BURST_W = 8;
  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;
  typedef struct packed {
    logic [ADDR_W-1:0]  addr;
    logic [BURST_W-1:0] burstcnt;
  } pend_t;
  function automatic logic [BURST_W-1:0] fix_burst(input logic [BURST_W-1:0] b);
    return b == '0 ? BURST_W'(1) : b;
  endfunction
endpackage

// File: rtl/msu_rr_arb2.sv
// msu_rr_arb2: two-way round-robin pick, the client that was not served last wins a tie
module msu_rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       grant,
  output logic       valid
);
  // sole requester wins outright; on a tie the other client than last goes first
  always_comb begin
    valid = |req;
    grant = &req ? ~last : req[1];
  end
endmodule

// File: rtl/msu_ddram_arbiter.sv
// msu_ddram_arbiter: shares the MSU1 DDRAM read port between the data streamer and audio fetcher
module msu_ddram_arbiter
  import msu_ddram_pkg::*;
(
  input  logic               DDRAM_CLK,
  input  logic               reset,
  input  logic               DDRAM_BUSY,
  output logic [BURST_W-1:0] DDRAM_BURSTCNT,
  output logic [ADDR_W-1:0]  DDRAM_ADDR,
  output logic               DDRAM_RD,
  input  logic [DATA_W-1:0]  DDRAM_DOUT,
  input  logic               DDRAM_DOUT_READY,
  output logic [DATA_W-1:0]  DDRAM_DIN,
  output logic [7:0]         DDRAM_BE,
  output logic               DDRAM_WE,
  input  logic [ADDR_W-1:0]  c0_addr,
  input  logic [BURST_W-1:0] c0_burstcnt,
  input  logic               c0_rd,
  output logic               c0_busy,
  output logic [DATA_W-1:0]  c0_dout,
  output logic               c0_dout_ready,
  input  logic [ADDR_W-1:0]  c1_addr,
  input  logic [BURST_W-1:0] c1_burstcnt,
  input  logic               c1_rd,
  output logic               c1_busy,
  output logic [DATA_W-1:0]  c1_dout,
  output logic               c1_dout_ready
);
  state_t             state, state_n;
  pend_t              pend [2];
  logic [1:0]         pend_v, take, clr;
  logic               owner, owner_n, last, last_n, grant, gnt_v, issue_ok, beat, rd_n;
  logic [BURST_W-1:0] beats, beats_n, bc_n;
  logic [ADDR_W-1:0]  addr_n;
  assign DDRAM_DIN = '0;
  assign DDRAM_BE  = 8'hFF;
  assign DDRAM_WE  = 1'b0;
  // a client is busy while its slot is full or its own burst is in flight
  always_comb begin
    c0_busy       = pend_v[0] | (state != ST_IDLE & ~owner);
    c1_busy       = pend_v[1] | (state != ST_IDLE & owner);
    take          = {c1_rd & ~c1_busy, c0_rd & ~c0_busy};
    issue_ok      = state == ST_ISSUE & ~DDRAM_BUSY;
    beat          = DDRAM_DOUT_READY & (state == ST_WAIT | issue_ok);
    c0_dout       = DDRAM_DOUT;
    c1_dout       = DDRAM_DOUT;
    c0_dout_ready = beat & ~owner;
    c1_dout_ready = beat & owner;
  end
  msu_rr_arb2 u_rr (
    .req  (pend_v),
    .last (last),
    .grant(grant),
    .valid(gnt_v)
  );
  // next-state: grant from idle, drop the command once taken, count beats down to the last
  always_comb begin
    state_n = state;
    owner_n = owner;
    last_n  = last;
    beats_n = beats;
    rd_n    = DDRAM_RD;
    addr_n  = DDRAM_ADDR;
    bc_n    = DDRAM_BURSTCNT;
    clr     = '0;
    if (state == ST_IDLE && gnt_v) begin
      state_n    = ST_ISSUE;
      owner_n    = grant;
      last_n     = grant;
      rd_n       = 1'b1;
      addr_n     = pend[grant].addr;
      bc_n       = pend[grant].burstcnt;
      beats_n    = pend[grant].burstcnt;
      clr[grant] = 1'b1;
    end
    if (issue_ok) begin
      rd_n    = 1'b0;
      state_n = ST_WAIT;
    end
    if (beat) begin
      beats_n = beats - 1'b1;
      state_n = beats == BURST_W'(1) ? ST_IDLE : state_n;
    end
  end
  // control state and the DDRAM command registers
  always_ff @(posedge DDRAM_CLK or posedge reset)
    if (reset) begin
      state          <= ST_IDLE;
      owner          <= 1'b0;
      last           <= 1'b1;
      beats          <= '0;
      DDRAM_RD       <= 1'b0;
      DDRAM_ADDR     <= '0;
      DDRAM_BURSTCNT <= '0;
    end else begin
      state          <= state_n;
      owner          <= owner_n;
      last           <= last_n;
      beats          <= beats_n;
      DDRAM_RD       <= rd_n;
      DDRAM_ADDR     <= addr_n;
      DDRAM_BURSTCNT <= bc_n;
    end
  // one pending slot per client; a zero burst length is stored as one beat
  always_ff @(posedge DDRAM_CLK or posedge reset)
    if (reset) begin
      pend_v  <= '0;
      pend[0] <= '0;
      pend[1] <= '0;
    end else begin
      pend_v <= (pend_v & ~clr) | take;
      if (take[0]) pend[0] <= pend_t'({c0_addr, fix_burst(c0_burstcnt)});
      if (take[1]) pend[1] <= pend_t'({c1_addr, fix_burst(c1_burstcnt)});
    end
endmodule

// File: tb/tb_msu_ddram_arbiter.sv
// tb_msu_ddram_arbiter: directed vectors and corner sequences for the DDRAM read arbiter
module tb_msu_ddram_arbiter;
  import msu_ddram_pkg::*;
  typedef struct {
    int                 c;
    logic [ADDR_W-1:0]  addr;
    logic [BURST_W-1:0] bc;
    int                 stall;
    logic [BURST_W-1:0] exp_bc;
  } vec_t;
  logic               clk = 1'b0, reset = 1'b1;
  logic               DDRAM_BUSY = 1'b0, DDRAM_DOUT_READY = 1'b0;
  logic [DATA_W-1:0]  DDRAM_DOUT = '0;
  logic [BURST_W-1:0] DDRAM_BURSTCNT;
  logic [ADDR_W-1:0]  DDRAM_ADDR;
  logic               DDRAM_RD, DDRAM_WE;
  logic [DATA_W-1:0]  DDRAM_DIN;
  logic [7:0]         DDRAM_BE;
  logic [ADDR_W-1:0]  c0_addr = '0, c1_addr = '0;
  logic [BURST_W-1:0] c0_burstcnt = '0, c1_burstcnt = '0;
  logic               c0_rd = 1'b0, c1_rd = 1'b0;
  logic               c0_busy, c1_busy, c0_dout_ready, c1_dout_ready;
  logic [DATA_W-1:0]  c0_dout, c1_dout;
  int                 checks = 0, errors = 0, cmds = 0;
  vec_t               v [4];
  msu_ddram_arbiter dut (
    .DDRAM_CLK(clk), .reset(reset), .DDRAM_BUSY(DDRAM_BUSY),
    .DDRAM_BURSTCNT(DDRAM_BURSTCNT), .DDRAM_ADDR(DDRAM_ADDR), .DDRAM_RD(DDRAM_RD),
    .DDRAM_DOUT(DDRAM_DOUT), .DDRAM_DOUT_READY(DDRAM_DOUT_READY),
    .DDRAM_DIN(DDRAM_DIN), .DDRAM_BE(DDRAM_BE), .DDRAM_WE(DDRAM_WE),
    .c0_addr(c0_addr), .c0_burstcnt(c0_burstcnt), .c0_rd(c0_rd), .c0_busy(c0_busy),
    .c0_dout(c0_dout), .c0_dout_ready(c0_dout_ready),
    .c1_addr(c1_addr), .c1_burstcnt(c1_burstcnt), .c1_rd(c1_rd), .c1_busy(c1_busy),
    .c1_dout(c1_dout), .c1_dout_ready(c1_dout_ready)
  );
  always #5 clk = ~clk;
  // commands actually taken by the DDRAM
  always @(posedge clk) if (DDRAM_RD && !DDRAM_BUSY && !reset) cmds <= cmds + 1;
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h want %0h", n, a, e);
    end
  endtask
  task automatic req(input int c, input logic [ADDR_W-1:0] a, input logic [BURST_W-1:0] b);
    @(negedge clk);
    if (c == 0) begin c0_rd = 1'b1; c0_addr = a; c0_burstcnt = b; end
    else begin c1_rd = 1'b1; c1_addr = a; c1_burstcnt = b; end
    @(negedge clk);
    c0_rd = 1'b0;
    c1_rd = 1'b0;
  endtask
  task automatic wait_rd(output int lat);
    lat = 0;
    while (!DDRAM_RD && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("rd_seen", DDRAM_RD, 1);
  endtask
  task automatic beats(input int c, input int n);
    for (int i = 0; i < n; i++) begin
      DDRAM_DOUT_READY = 1'b1;
      DDRAM_DOUT = 64'hC0DE_0000_0000_0000 + 64'(i * 16 + c);
      #1;
      chk("beat_own", c != 0 ? c1_dout_ready : c0_dout_ready, 1);
      chk("beat_other", c != 0 ? c0_dout_ready : c1_dout_ready, 0);
      chk("beat_data", c != 0 ? c1_dout : c0_dout, DDRAM_DOUT);
      @(negedge clk);
    end
    DDRAM_DOUT_READY = 1'b0;
  endtask
  task automatic tie(input int first);
    int lat, c;
    @(negedge clk);
    c0_rd = 1'b1; c0_addr = 29'h10; c0_burstcnt = 8'd1;
    c1_rd = 1'b1; c1_addr = 29'h20; c1_burstcnt = 8'd4;
    @(negedge clk);
    c0_rd = 1'b0;
    c1_rd = 1'b0;
    for (int k = 0; k < 2; k++) begin
      c = k == 0 ? first : 1 - first;
      wait_rd(lat);
      chk("tie_lat", lat, 1);
      chk("tie_addr", DDRAM_ADDR, c != 0 ? 29'h20 : 29'h10);
      chk("tie_bc", DDRAM_BURSTCNT, c != 0 ? 8'd4 : 8'd1);
      @(negedge clk);
      beats(c, c != 0 ? 4 : 1);
    end
  endtask
  initial begin
    int lat, base;
    v[0] = '{0, 29'h100, 8'd2, 0, 8'd2};
    v[1] = '{1, 29'h2000, 8'd3, 5, 8'd3};
    v[2] = '{1, 29'h55, 8'd0, 0, 8'd1};
    v[3] = '{0, 29'h1FFF_FFFF, 8'd1, 2, 8'd1};
    @(negedge clk);
    chk("rst_rd", DDRAM_RD, 0);
    chk("rst_addr", DDRAM_ADDR, 0);
    chk("rst_bc", DDRAM_BURSTCNT, 0);
    chk("rst_busy", {c0_busy, c1_busy}, 0);
    chk("rst_drdy", {c0_dout_ready, c1_dout_ready}, 0);
    chk("const_din", DDRAM_DIN, 0);
    chk("const_be", DDRAM_BE, 8'hFF);
    chk("const_we", DDRAM_WE, 0);
    reset = 1'b0;
    tie(0);
    for (int i = 0; i < 4; i++) begin
      base = cmds;
      req(v[i].c, v[i].addr, v[i].bc);
      wait_rd(lat);
      chk("vec_lat", lat, 1);
      chk("vec_addr", DDRAM_ADDR, v[i].addr);
      chk("vec_bc", DDRAM_BURSTCNT, v[i].exp_bc);
      DDRAM_BUSY = v[i].stall != 0;
      for (int k = 0; k < v[i].stall; k++) begin
        @(negedge clk);
        chk("stall_rd", DDRAM_RD, 1);
        chk("stall_addr", DDRAM_ADDR, v[i].addr);
        chk("stall_bc", DDRAM_BURSTCNT, v[i].exp_bc);
        DDRAM_DOUT_READY = 1'b1;
        #1;
        chk("stray_issue", {c0_dout_ready, c1_dout_ready}, 0);
        DDRAM_DOUT_READY = 1'b0;
      end
      DDRAM_BUSY = 1'b0;
      @(negedge clk);
      chk("rd_drop", DDRAM_RD, 0);
      chk("owner_busy", v[i].c != 0 ? c1_busy : c0_busy, 1);
      beats(v[i].c, int'(v[i].exp_bc));
      chk("busy_rel", v[i].c != 0 ? c1_busy : c0_busy, 0);
      chk("one_cmd", cmds - base, 1);
    end
    tie(1);
    base = cmds;
    req(0, 29'h300, 8'd2);
    wait_rd(lat);
    @(negedge clk);
    c0_rd = 1'b1; c0_addr = 29'h999; c0_burstcnt = 8'd7;
    #1;
    chk("guard_busy", c0_busy, 1);
    @(negedge clk);
    c0_rd = 1'b0;
    beats(0, 2);
    repeat (3) @(negedge clk);
    chk("guard_no_rd", DDRAM_RD, 0);
    chk("guard_cmds", cmds - base, 1);
    chk("guard_busy_rel", c0_busy, 0);
    base = cmds;
    req(1, 29'h400, 8'd4);
    wait_rd(lat);
    @(negedge clk);
    beats(1, 1);
    reset = 1'b1;
    #1;
    chk("rst_mid_rd", DDRAM_RD, 0);
    chk("rst_mid_busy", c1_busy, 0);
    chk("rst_mid_addr", DDRAM_ADDR, 0);
    @(negedge clk);
    reset = 1'b0;
    DDRAM_DOUT_READY = 1'b1;
    #1;
    chk("rst_stray", {c0_dout_ready, c1_dout_ready}, 0);
    @(negedge clk);
    DDRAM_DOUT_READY = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_no_rd", DDRAM_RD, 0);
    chk("rst_cmds", cmds - base, 1);
    chk("rst_idle_busy", {c0_busy, c1_busy}, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
